requantize_scale_fetcher: RTL and testbench

Sequencer on the requester side of the requantize scale ROM. On a `start` pulse it walks one layer's scale entries, weight scales `0..N-1` followed by the output scale at index `N`. It issues one ROM read per cycle under credit-based flow control, captures each returned `{mult, shift}` pair after the ROM's fixed 1-cycle read latency, and streams the pairs in order to the requantization datapath over a valid/ready interface. The block sits between the layer controller and the requantizer, and it ensures no ROM read result is lost, since the ROM itself cannot apply backpressure.

---
 rtl/requantize_scale_fetcher_if.sv | 40 ++++
 rtl/requantize_scale_fetcher.sv | 134 +++++++++++++
 tb/tb_requantize_scale_fetcher.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/requantize_scale_fetcher_if.sv
// Request, scale-ROM and requantizer-stream signals of the scale fetcher.
// Latency: none, wiring only.
// Backpressure: out_ready stalls the stream; the ROM side relies on the fetcher's read credits.
interface requantize_scale_fetcher_if #(
    parameter int NUM_LAYERS  = 28,
    parameter int MULT_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 6,
    parameter int IDX_WIDTH   = 8
) ();
    localparam int LW = $clog2(NUM_LAYERS + 1);

    logic                          start;
    logic signed [LW-1:0]          start_layer_idx;
    logic        [IDX_WIDTH-1:0]   num_weights;
    logic                          busy;
    logic                          done;
    logic                          rom_valid;
    logic signed [LW-1:0]          rom_layer_idx;
    logic        [IDX_WIDTH-1:0]   rom_weight_idx;
    logic signed [MULT_WIDTH-1:0]  rom_mult;
    logic signed [SHIFT_WIDTH-1:0] rom_shift;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [MULT_WIDTH-1:0]  out_mult;
    logic signed [SHIFT_WIDTH-1:0] out_shift;
    logic        [IDX_WIDTH-1:0]   out_idx;
    logic                          out_last;

    modport master (
        input  start, start_layer_idx, num_weights, rom_mult, rom_shift, out_ready,
        output busy, done, rom_valid, rom_layer_idx, rom_weight_idx,
               out_valid, out_mult, out_shift, out_idx, out_last
    );

    modport slave (
        output start, start_layer_idx, num_weights, rom_mult, rom_shift, out_ready,
        input  busy, done, rom_valid, rom_layer_idx, rom_weight_idx,
               out_valid, out_mult, out_shift, out_idx, out_last
    );
endinterface

// File: rtl/requantize_scale_fetcher.sv
// Walks a layer's N weight scales plus its output scale out of the requantize ROM into a stream.
// Latency: first entry valid 3 cycles after start is sampled; then one entry per cycle.
// Backpressure: out_ready stalls the output FIFO; ROM reads are credited so no read result is ever dropped.
module requantize_scale_fetcher #(
    parameter int NUM_LAYERS  = 28,
    parameter int MULT_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 6,
    parameter int IDX_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    requantize_scale_fetcher_if.master  bus
);
    localparam int LW = $clog2(NUM_LAYERS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    typedef struct packed {
        logic signed [MULT_WIDTH-1:0]  mult;
        logic signed [SHIFT_WIDTH-1:0] shift;
        logic        [IDX_WIDTH-1:0]   idx;
        logic                          last;
    } entry_t;

    state_t               state, state_nxt;
    logic signed [LW-1:0] layer_q;
    logic [IDX_WIDTH-1:0] n_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic [IDX_WIDTH-1:0] idx_d;
    logic                 pending;
    logic                 done_q;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;
    logic [CW-1:0]        credit_used;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    entry_t               mem [FIFO_DEPTH];
    entry_t               wr_entry;
    entry_t               head;
    logic                 accept;
    logic                 issue;
    logic                 finish;
    logic                 push;
    logic                 pop;

    // done_q still blocks start: the done cycle is already IDLE but must not accept a new request
    assign accept      = (state == IDLE) && !done_q && bus.start;
    // an in-flight read already owns a FIFO slot, so it counts against the credit
    assign credit_used = count + CW'(pending);
    assign push        = pending;
    assign pop         = (count != '0) && bus.out_ready;
    assign count_nxt   = count + CW'(push) - CW'(pop);

    assign wr_entry.mult  = bus.rom_mult;
    assign wr_entry.shift = bus.rom_shift;
    assign wr_entry.idx   = idx_d;
    assign wr_entry.last  = (idx_d == n_q);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = FETCH;
            end
            FETCH: begin
                if (credit_used < CW'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (idx_q == n_q) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // look at next-cycle occupancy so done lands the cycle right after the last pop
                if (!pending && count_nxt == '0) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            layer_q <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            idx_d   <= '0;
            pending <= 1'b0;
            done_q  <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            state   <= state_nxt;
            done_q  <= finish;
            pending <= issue;
            count   <= count_nxt;
            if (accept) begin
                layer_q <= bus.start_layer_idx;
                n_q     <= bus.num_weights;
                idx_q   <= '0;
            end
            if (issue) begin
                idx_q <= idx_q + IDX_WIDTH'(1);
                idx_d <= idx_q;
            end
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    assign head = mem[rd_ptr];

    assign bus.busy           = (state != IDLE);
    assign bus.done           = done_q;
    assign bus.rom_valid      = issue;
    assign bus.rom_layer_idx  = layer_q;
    assign bus.rom_weight_idx = issue ? idx_q : idx_d;
    assign bus.out_valid      = (count != '0);
    assign bus.out_mult       = head.mult;
    assign bus.out_shift      = head.shift;
    assign bus.out_idx        = head.idx;
    assign bus.out_last       = head.last;
endmodule

// File: tb/tb_requantize_scale_fetcher.sv
// Directed bench for requantize_scale_fetcher: a 1-cycle-latency ROM model, a negedge monitor
// logging reads/pops/done, a table of unstalled fetches and hand-written stall/reset/start sequences.
module tb_requantize_scale_fetcher;
    localparam int NL = 28;
    localparam int MW = 32;
    localparam int SW = 6;
    localparam int IW = 8;
    localparam int FD = 4;
    localparam int LW = $clog2(NL + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    requantize_scale_fetcher_if #(.NUM_LAYERS(NL), .MULT_WIDTH(MW), .SHIFT_WIDTH(SW), .IDX_WIDTH(IW)) bus ();

    requantize_scale_fetcher #(
        .NUM_LAYERS(NL), .MULT_WIDTH(MW), .SHIFT_WIDTH(SW), .IDX_WIDTH(IW), .FIFO_DEPTH(FD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic signed [MW-1:0] mmodel(input logic signed [LW-1:0] l, input logic [IW-1:0] i);
        return MW'(l) * 32'sd65536 + MW'(i) * 3 + 32'sd11;
    endfunction

    function automatic logic signed [SW-1:0] smodel(input logic signed [LW-1:0] l, input logic [IW-1:0] i);
        return SW'(i) + SW'(l) - SW'(7);
    endfunction

    // ROM drives zeros when not read and is deliberately not reset
    always @(posedge clk) begin
        if (bus.rom_valid) begin
            bus.rom_mult  <= mmodel(bus.rom_layer_idx, bus.rom_weight_idx);
            bus.rom_shift <= smodel(bus.rom_layer_idx, bus.rom_weight_idx);
        end else begin
            bus.rom_mult  <= '0;
            bus.rom_shift <= '0;
        end
    end

    typedef struct {int c; logic signed [LW-1:0] layer; logic [IW-1:0] idx;} rd_rec_t;
    typedef struct {int c; logic signed [MW-1:0] mult; logic signed [SW-1:0] shift; logic [IW-1:0] idx; logic last;} out_rec_t;
    typedef struct {int c; logic busy;} done_rec_t;

    rd_rec_t   rd_log[$];
    out_rec_t  out_log[$];
    done_rec_t done_log[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rom_valid) rd_log.push_back('{cyc, bus.rom_layer_idx, bus.rom_weight_idx});
            if (bus.out_valid && bus.out_ready)
                out_log.push_back('{cyc, bus.out_mult, bus.out_shift, bus.out_idx, bus.out_last});
            if (bus.done) done_log.push_back('{cyc, bus.busy});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        out_log.delete();
        done_log.delete();
    endtask

    // call at posedge+1; t0 is chosen so the first read lands in cycle t0+1
    task automatic do_start(input logic signed [LW-1:0] l, input logic [IW-1:0] n, output int t0);
        bus.start           = 1'b1;
        bus.start_layer_idx = l;
        bus.num_weights     = n;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t0 = cyc - 1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_log.size() == 0 && k < budget) begin
            step(1);
            k++;
        end
        chk($sformatf("%s done_timeout", tag), done_log.size() > 0, 1'b1);
        step(2);
    endtask

    task automatic check_run(input string tag, input logic signed [LW-1:0] l, input logic [IW-1:0] n,
                             input int t0, input int done_off, input bit timing);
        int ne = int'(n) + 1;
        logic signed [MW-1:0] em;
        logic signed [SW-1:0] es;
        chk($sformatf("%s n_reads", tag), rd_log.size(), ne);
        for (int i = 0; i < ne && i < rd_log.size(); i++) begin
            chk($sformatf("%s rd_idx[%0d]", tag, i), rd_log[i].idx, i);
            chk($sformatf("%s rd_layer[%0d]", tag, i), rd_log[i].layer, l);
            if (timing) chk($sformatf("%s rd_cyc[%0d]", tag, i), rd_log[i].c - t0, 1 + i);
        end
        chk($sformatf("%s n_out", tag), out_log.size(), ne);
        for (int i = 0; i < ne && i < out_log.size(); i++) begin
            em = mmodel(l, IW'(i));
            es = smodel(l, IW'(i));
            chk($sformatf("%s out_idx[%0d]", tag, i), out_log[i].idx, i);
            chk($sformatf("%s out_last[%0d]", tag, i), out_log[i].last, i == ne - 1);
            chk($sformatf("%s out_mult[%0d]", tag, i), out_log[i].mult, em);
            chk($sformatf("%s out_shift[%0d]", tag, i), out_log[i].shift, es);
            if (timing) chk($sformatf("%s out_cyc[%0d]", tag, i), out_log[i].c - t0, 3 + i);
        end
        chk($sformatf("%s n_done", tag), done_log.size(), 1);
        if (done_log.size() > 0) begin
            chk($sformatf("%s busy_at_done", tag), done_log[0].busy, 1'b0);
            if (timing) chk($sformatf("%s done_cyc", tag), done_log[0].c - t0, done_off);
        end
    endtask

    typedef struct {
        logic signed [LW-1:0] layer;
        logic [IW-1:0]        n;
        int                   done_off;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int   t0;
        int   tx;
        int   k;
        int   nrd;

        vecs[0] = '{5'sd2,  8'd3, 7};
        vecs[1] = '{-5'sd1, 8'd8, 12};
        vecs[2] = '{5'sd0,  8'd0, 4};
        vecs[3] = '{5'sd9,  8'd1, 5};

        bus.start           = 1'b0;
        bus.start_layer_idx = '0;
        bus.num_weights     = '0;
        bus.out_ready       = 1'b1;
        rst_n               = 1'b0;
        step(2);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst done", bus.done, 1'b0);
        chk("rst rom_valid", bus.rom_valid, 1'b0);
        chk("rst out_valid", bus.out_valid, 1'b0);
        chk("rst out_last", bus.out_last, 1'b0);
        chk("rst rom_layer_idx", bus.rom_layer_idx, 0);
        chk("rst rom_weight_idx", bus.rom_weight_idx, 0);
        chk("rst out_mult", bus.out_mult, 0);
        chk("rst out_shift", bus.out_shift, 0);
        chk("rst out_idx", bus.out_idx, 0);
        rst_n = 1'b1;
        step(1);

        for (int v = 0; v < 4; v++) begin
            clear_logs();
            do_start(vecs[v].layer, vecs[v].n, t0);
            wait_done($sformatf("vec%0d", v), 60);
            check_run($sformatf("vec%0d", v), vecs[v].layer, vecs[v].n, t0, vecs[v].done_off, 1'b1);
        end

        // credit stall: four reads fill the FIFO, one pop frees exactly one more read
        clear_logs();
        bus.out_ready = 1'b0;
        do_start(5'sd3, 8'd9, t0);
        step(10);
        chk("bp reads_stalled", rd_log.size(), 4);
        chk("bp rom_valid_low", bus.rom_valid, 1'b0);
        chk("bp out_valid", bus.out_valid, 1'b1);
        chk("bp no_pops", out_log.size(), 0);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        step(5);
        chk("bp reads_after_pop", rd_log.size(), 5);
        chk("bp pops_after_pulse", out_log.size(), 1);
        bus.out_ready = 1'b1;
        wait_done("bp", 80);
        check_run("bp", 5'sd3, 8'd9, t0, 0, 1'b0);

        // start during FETCH with another layer must be ignored
        clear_logs();
        bus.out_ready = 1'b0;
        do_start(5'sd4, 8'd5, t0);
        step(2);
        do_start(5'sd7, 8'd2, tx);
        step(2);
        chk("ign rom_layer_idx", bus.rom_layer_idx, 5'sd4);
        bus.out_ready = 1'b1;
        wait_done("ign", 80);
        check_run("ign", 5'sd4, 8'd5, t0, 0, 1'b0);

        // start raised in the done cycle must be ignored
        clear_logs();
        do_start(5'sd1, 8'd2, t0);
        k = 0;
        while (!bus.done && k < 40) begin
            step(1);
            k++;
        end
        chk("bb saw_done", bus.done, 1'b1);
        bus.start           = 1'b1;
        bus.start_layer_idx = 5'sd6;
        bus.num_weights     = 8'd1;
        step(1);
        bus.start = 1'b0;
        chk("bb busy_after_done", bus.busy, 1'b0);
        step(4);
        chk("bb still_idle", bus.busy, 1'b0);
        check_run("bb", 5'sd1, 8'd2, t0, 6, 1'b1);

        // reset while a read result is in flight and the FIFO holds data
        clear_logs();
        do_start(5'sd2, 8'd3, t0);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("mrst busy", bus.busy, 1'b0);
        chk("mrst rom_valid", bus.rom_valid, 1'b0);
        chk("mrst out_valid", bus.out_valid, 1'b0);
        chk("mrst out_last", bus.out_last, 1'b0);
        chk("mrst rom_layer_idx", bus.rom_layer_idx, 0);
        chk("mrst rom_weight_idx", bus.rom_weight_idx, 0);
        chk("mrst out_mult", bus.out_mult, 0);
        chk("mrst out_idx", bus.out_idx, 0);
        #1;
        rst_n = 1'b1;
        step(4);
        chk("mrst no_stray_push", bus.out_valid, 1'b0);
        nrd = out_log.size();
        chk("mrst no_stray_pop", nrd, 0);
        chk("mrst idle", bus.busy, 1'b0);
        clear_logs();
        do_start(5'sd0, 8'd1, t0);
        wait_done("post_rst", 60);
        check_run("post_rst", 5'sd0, 8'd1, t0, 5, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
